copperv_core: RTL and testbench

- Minimal multicycle RV32I integer CPU. It has separate instruction and data memory ports, each with four independent valid/ready channels: read address, read data, write address and write data.
- It is the top-level CPU instantiated as `dut` in system benches, between two native memory models.
- Its 32-entry register file is a submodule instance `regfile` holding array `memory[0:31]`, which benches read hierarchically.

---
 rtl/copperv_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_copperv_core.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/copperv_core.sv
// copperv_core: minimal multicycle RV32I CPU with split valid/ready
// instruction and data ports. Optional retire trace port enabled by
// defining COPPERV_RETIRE_PORT_EN.

module copperv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wen,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);
  logic [31:0] memory [0:31];

  // Whole file cleared on reset; x0 is never written afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) memory[i] <= '0;
    end else if (wen && rd_addr != 5'd0) begin
      memory[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : memory[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : memory[rs2_addr];
endmodule

module copperv_core #(
  parameter int          bus_width = 32,
  parameter logic [31:0] pc_init   = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 i_raddr_valid,
  input  logic                 i_raddr_ready,
  output logic [bus_width-1:0] i_raddr,
  input  logic                 i_rdata_valid,
  output logic                 i_rdata_ready,
  input  logic [bus_width-1:0] i_rdata,
  output logic                 i_waddr_valid,
  input  logic                 i_waddr_ready,
  output logic [bus_width-1:0] i_waddr,
  output logic                 i_wdata_valid,
  input  logic                 i_wdata_ready,
  output logic [bus_width-1:0] i_wdata,
  output logic                 d_raddr_valid,
  input  logic                 d_raddr_ready,
  output logic [bus_width-1:0] d_raddr,
  input  logic                 d_rdata_valid,
  output logic                 d_rdata_ready,
  input  logic [bus_width-1:0] d_rdata,
  output logic                 d_waddr_valid,
  input  logic                 d_waddr_ready,
  output logic [bus_width-1:0] d_waddr,
  output logic                 d_wdata_valid,
  input  logic                 d_wdata_ready,
  output logic [bus_width-1:0] d_wdata
`ifdef COPPERV_RETIRE_PORT_EN
  ,
  output logic                 retire_valid,
  output logic [bus_width-1:0] retire_pc
`endif
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  typedef enum logic [2:0] {FETCH, WAIT_INST, EXEC, MEM_REQ, WAIT_LOAD, WRITEBACK} state_t;
  state_t state, next_state;

  logic [31:0] pc, inst, load_data, next_pc, pc_plus4;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_result, exec_result, rf_wdata, mem_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        waddr_done, wdata_done, store_done, exec_wen, rf_wen, taken;
  logic        is_lw, is_sw, alt_op;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        unused_ready;

  assign unused_ready = &{1'b0, i_waddr_ready, i_wdata_ready};
  assign i_waddr_valid = 1'b0;
  assign i_wdata_valid = 1'b0;
  assign i_waddr = '0;
  assign i_wdata = '0;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign is_lw  = (opcode == OP_LOAD) && (f3 == 3'b010);
  assign is_sw  = (opcode == OP_STORE) && (f3 == 3'b010);
  assign pc_plus4 = pc + 32'd4;
  assign mem_addr = rs1_val + (is_sw ? imm_s : imm_i);
  assign store_done = is_sw && (waddr_done || d_waddr_ready) && (wdata_done || d_wdata_ready);

  copperv_regfile regfile (
    .clk(clk), .rst(rst),
    .rs1_addr(inst[19:15]), .rs2_addr(inst[24:20]),
    .rs1_data(rs1_val), .rs2_data(rs2_val),
    .wen(rf_wen), .rd_addr(inst[11:7]), .rd_data(rf_wdata)
  );

  // Shared ALU for register and immediate forms; bit 30 only selects SUB on
  // register ops, since on immediates it is part of the constant
  always_comb begin
    alu_b  = (opcode == OP_REG) ? rs2_val : imm_i;
    alt_op = inst[30] && ((opcode == OP_REG) || (f3 == 3'b101));
    case (f3)
      3'b000:  alu_result = alt_op ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_result = rs1_val << alu_b[4:0];
      3'b010:  alu_result = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_result = {31'b0, rs1_val < alu_b};
      3'b100:  alu_result = rs1_val ^ alu_b;
      3'b101:  alu_result = alt_op ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'b110:  alu_result = rs1_val | alu_b;
      default: alu_result = rs1_val & alu_b;
    endcase
  end

  // Branch condition and EXEC result / next PC selection
  always_comb begin
    case (f3)
      3'b000:  taken = rs1_val == rs2_val;
      3'b001:  taken = rs1_val != rs2_val;
      3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  taken = rs1_val < rs2_val;
      3'b111:  taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
    exec_wen    = 1'b0;
    exec_result = '0;
    next_pc     = pc_plus4;
    case (opcode)
      OP_LUI:   begin exec_wen = 1'b1; exec_result = imm_u; end
      OP_AUIPC: begin exec_wen = 1'b1; exec_result = pc + imm_u; end
      OP_JAL:   begin exec_wen = 1'b1; exec_result = pc_plus4; next_pc = pc + imm_j; end
      OP_JALR:  if (f3 == 3'b000) begin
                  exec_wen = 1'b1; exec_result = pc_plus4;
                  next_pc = (rs1_val + imm_i) & ~32'd1;
                end
      OP_BRANCH: if (taken) next_pc = pc + imm_b;
      OP_IMM, OP_REG: begin exec_wen = 1'b1; exec_result = alu_result; end
      default: ;
    endcase
    rf_wen   = (state == EXEC && exec_wen) || (state == WRITEBACK);
    rf_wdata = (state == WRITEBACK) ? load_data : exec_result;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // Next state and bus outputs; every output is forced low while in reset
  always_comb begin
    next_state    = state;
    i_raddr_valid = 1'b0;
    i_raddr       = '0;
    i_rdata_ready = 1'b0;
    d_raddr_valid = 1'b0;
    d_raddr       = '0;
    d_rdata_ready = 1'b0;
    d_waddr_valid = 1'b0;
    d_waddr       = '0;
    d_wdata_valid = 1'b0;
    d_wdata       = '0;
    case (state)
      FETCH: begin
        i_raddr_valid = 1'b1;
        i_raddr       = pc;
        if (i_raddr_ready) next_state = WAIT_INST;
      end
      WAIT_INST: begin
        i_rdata_ready = 1'b1;
        if (i_rdata_valid) next_state = EXEC;
      end
      EXEC: next_state = (is_lw || is_sw) ? MEM_REQ : FETCH;
      MEM_REQ: begin
        if (is_lw) begin
          d_raddr_valid = 1'b1;
          d_raddr       = mem_addr;
          if (d_raddr_ready) next_state = WAIT_LOAD;
        end else begin
          d_waddr_valid = !waddr_done;
          d_waddr       = mem_addr;
          d_wdata_valid = !wdata_done;
          d_wdata       = rs2_val;
          if (store_done) next_state = FETCH;
        end
      end
      WAIT_LOAD: begin
        d_rdata_ready = 1'b1;
        if (d_rdata_valid) next_state = WRITEBACK;
      end
      default: next_state = FETCH;
    endcase
    if (rst) begin
      i_raddr_valid = 1'b0; i_raddr = '0; i_rdata_ready = 1'b0;
      d_raddr_valid = 1'b0; d_raddr = '0; d_rdata_ready = 1'b0;
      d_waddr_valid = 1'b0; d_waddr = '0; d_wdata_valid = 1'b0; d_wdata = '0;
    end
  end

  // Datapath registers: PC, instruction latch, load data, store progress
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= pc_init;
      inst       <= '0;
      load_data  <= '0;
      waddr_done <= 1'b0;
      wdata_done <= 1'b0;
    end else begin
      case (state)
        WAIT_INST: if (i_rdata_valid) inst <= i_rdata;
        EXEC:      if (!(is_lw || is_sw)) pc <= next_pc;
        MEM_REQ:   if (is_sw) begin
                     if (store_done) begin
                       waddr_done <= 1'b0;
                       wdata_done <= 1'b0;
                       pc         <= pc_plus4;
                     end else begin
                       if (d_waddr_valid && d_waddr_ready) waddr_done <= 1'b1;
                       if (d_wdata_valid && d_wdata_ready) wdata_done <= 1'b1;
                     end
                   end
        WAIT_LOAD: if (d_rdata_valid) load_data <= d_rdata;
        WRITEBACK: pc <= pc_plus4;
        default: ;
      endcase
    end
  end

`ifdef COPPERV_RETIRE_PORT_EN
  assign retire_valid = !rst && (((state == EXEC || state == MEM_REQ) && next_state == FETCH) ||
                                 state == WRITEBACK);
  assign retire_pc    = rst ? '0 : pc;
`endif
endmodule

// File: tb/tb_copperv_core.sv
// Directed bench for copperv_core with simple instruction/data memory models.
module tb_copperv_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
  logic        i_waddr_valid, i_waddr_ready, i_wdata_valid, i_wdata_ready;
  logic [31:0] i_raddr, i_rdata, i_waddr, i_wdata;
  logic        d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
  logic        d_waddr_valid, d_waddr_ready, d_wdata_valid, d_wdata_ready;
  logic [31:0] d_raddr, d_rdata, d_waddr, d_wdata;

  copperv_core #(.bus_width(32), .pc_init(32'h0)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
    .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
    .i_waddr_valid(i_waddr_valid), .i_waddr_ready(i_waddr_ready), .i_waddr(i_waddr),
    .i_wdata_valid(i_wdata_valid), .i_wdata_ready(i_wdata_ready), .i_wdata(i_wdata),
    .d_raddr_valid(d_raddr_valid), .d_raddr_ready(d_raddr_ready), .d_raddr(d_raddr),
    .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready), .d_rdata(d_rdata),
    .d_waddr_valid(d_waddr_valid), .d_waddr_ready(d_waddr_ready), .d_waddr(d_waddr),
    .d_wdata_valid(d_wdata_valid), .d_wdata_ready(d_wdata_ready), .d_wdata(d_wdata)
  );

  localparam logic [31:0] NOP = 32'h00000013;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory models
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic        i_pend = 1'b0, d_pend = 1'b0, wa_have = 1'b0, wd_have = 1'b0;
  logic [31:0] i_data, d_data, last_waddr, last_wdata;
  logic        ld_hold = 1'b0;
  int          wa_delay = 0, wa_wait = 0, wa_cnt = 0, wd_cnt = 0;
  logic [31:0] flog [$];
  int          tlog [$];

  assign i_raddr_ready = 1'b1;
  assign i_rdata_valid = i_pend;
  assign i_rdata       = i_data;
  assign i_waddr_ready = 1'b0;
  assign i_wdata_ready = 1'b0;
  assign d_raddr_ready = 1'b1;
  assign d_rdata_valid = d_pend && !ld_hold;
  assign d_rdata       = d_data;
  assign d_wdata_ready = 1'b1;
  assign d_waddr_ready = (wa_wait >= wa_delay);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      i_pend <= 1'b0; d_pend <= 1'b0; wa_have <= 1'b0; wd_have <= 1'b0;
      wa_cnt <= 0; wd_cnt <= 0; wa_wait <= 0;
      flog.delete(); tlog.delete();
    end else begin
      if (i_rdata_valid && i_rdata_ready) i_pend <= 1'b0;
      if (i_raddr_valid && i_raddr_ready) begin
        i_pend <= 1'b1; i_data <= imem[i_raddr[7:2]];
        flog.push_back(i_raddr); tlog.push_back(cyc);
      end
      if (d_rdata_valid && d_rdata_ready) d_pend <= 1'b0;
      if (d_raddr_valid && d_raddr_ready) begin d_pend <= 1'b1; d_data <= dmem[d_raddr[7:2]]; end
      if (d_waddr_valid && d_waddr_ready) begin
        wa_cnt <= wa_cnt + 1; last_waddr <= d_waddr; wa_have <= 1'b1; wa_wait <= 0;
      end else if (d_waddr_valid) wa_wait <= wa_wait + 1;
      if (d_wdata_valid && d_wdata_ready) begin
        wd_cnt <= wd_cnt + 1; last_wdata <= d_wdata; wd_have <= 1'b1;
      end
      if (wa_have && wd_have) begin
        dmem[last_waddr[7:2]] <= last_wdata; wa_have <= 1'b0; wd_have <= 1'b0;
      end
    end
  end

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = NOP;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until(input logic [31:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (i_raddr_valid && i_raddr == target) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int nz;
    clear_imem();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({i_raddr_valid, i_rdata_ready, d_raddr_valid, d_rdata_ready, d_waddr_valid, d_wdata_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs_low got %b want 0",
        {i_raddr_valid, i_rdata_ready, d_raddr_valid, d_rdata_ready, d_waddr_valid, d_wdata_valid});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (i_raddr_valid !== 1'b1) begin errors++; $display("FAIL reset_fetch_valid got %b want 1", i_raddr_valid); end
    checks++;
    if (i_raddr !== 32'h0) begin errors++; $display("FAIL reset_fetch_addr got %h want 0", i_raddr); end
    checks++;
    if ({d_raddr_valid, d_waddr_valid, d_wdata_valid, i_waddr_valid, i_wdata_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_other_valids got %b want 0",
        {d_raddr_valid, d_waddr_valid, d_wdata_valid, i_waddr_valid, i_wdata_valid});
    end
    nz = 0;
    for (int i = 1; i < 32; i++) if (dut.regfile.memory[i] !== 32'h0) nz++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL reset_regs_clear got %0d nonzero want 0", nz); end
  endtask

  task automatic test_alu();
    bit ok;
    clear_imem();
    imem[0] = addi(5'd1, 5'd0, 12'd5);
    imem[1] = addi(5'd2, 5'd0, 12'hFFD);
    imem[2] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
    do_reset(2);
    run_until(32'h0C, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alu_timeout got 0 want 1"); end
    checks++;
    if (dut.regfile.memory[1] !== 32'd5) begin errors++; $display("FAIL alu_x1 got %h want 5", dut.regfile.memory[1]); end
    checks++;
    if (dut.regfile.memory[2] !== 32'hFFFFFFFD) begin errors++; $display("FAIL alu_x2 got %h want fffffffd", dut.regfile.memory[2]); end
    checks++;
    if (dut.regfile.memory[3] !== 32'd2) begin errors++; $display("FAIL alu_x3 got %h want 2", dut.regfile.memory[3]); end
    checks++;
    if (tlog.size() < 2 || tlog[1] - tlog[0] != 3) begin
      errors++; $display("FAIL alu_cycles got size %0d want 3 cycles per op", tlog.size());
    end
  endtask

  task automatic test_store_load(input int delay, input logic [11:0] value);
    bit ok;
    clear_imem();
    imem[0] = addi(5'd1, 5'd0, 12'h100);
    imem[1] = addi(5'd2, 5'd0, value);
    imem[2] = enc_s(12'd4, 5'd2, 5'd1);
    imem[3] = enc_i(12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011);
    wa_delay = delay;
    do_reset(2);
    run_until(32'h10, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sl_timeout delay %0d got 0 want 1", delay); end
    checks++;
    if (last_waddr !== 32'h104) begin errors++; $display("FAIL sl_waddr got %h want 104", last_waddr); end
    checks++;
    if (last_wdata !== {20'h0, value}) begin errors++; $display("FAIL sl_wdata got %h want %h", last_wdata, value); end
    checks++;
    if (wa_cnt != 1 || wd_cnt != 1) begin
      errors++; $display("FAIL sl_write_count got %0d/%0d want 1/1", wa_cnt, wd_cnt);
    end
    checks++;
    if (dut.regfile.memory[3] !== {20'h0, value}) begin
      errors++; $display("FAIL sl_x3 got %h want %h", dut.regfile.memory[3], value);
    end
    checks++;
    if (tlog.size() < 5 || tlog[3] - tlog[2] != 4 + delay || tlog[4] - tlog[3] != 6) begin
      errors++; $display("FAIL sl_cycles delay %0d got size %0d want sw %0d lw 6", delay, tlog.size(), 4 + delay);
    end
    wa_delay = 0;
  endtask

  task automatic test_branch_jump();
    bit ok;
    logic [31:0] exp_f [12];
    exp_f = '{32'h00, 32'h04, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h28, 32'h2C, 32'h30, 32'h34};
    clear_imem();
    imem[0]  = enc_b(13'd8, 5'd0, 5'd0, 3'b001);
    imem[1]  = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
    imem[2]  = addi(5'd6, 5'd0, 12'd1);
    imem[3]  = addi(5'd7, 5'd0, 12'd2);
    imem[8]  = enc_j(21'd8, 5'd1);
    imem[9]  = addi(5'd6, 5'd0, 12'd3);
    imem[10] = addi(5'd8, 5'd0, 12'h031);
    imem[11] = enc_i(12'd0, 5'd8, 3'b000, 5'd9, 7'b1100111);
    imem[12] = addi(5'd10, 5'd0, 12'd4);
    do_reset(2);
    run_until(32'h34, 200, ok);
    checks++;
    if (!ok || flog.size() < 12) begin errors++; $display("FAIL br_timeout got %0d fetches want 12", flog.size()); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= flog.size() || flog[i] !== exp_f[i]) begin
        errors++; $display("FAIL br_fetch_%0d got %h want %h", i, (i < flog.size()) ? flog[i] : 32'hx, exp_f[i]);
      end
    end
    checks++;
    if (dut.regfile.memory[6] !== 32'd0) begin errors++; $display("FAIL br_skipped_x6 got %h want 0", dut.regfile.memory[6]); end
    checks++;
    if (dut.regfile.memory[7] !== 32'd2) begin errors++; $display("FAIL br_x7 got %h want 2", dut.regfile.memory[7]); end
    checks++;
    if (dut.regfile.memory[1] !== 32'h24) begin errors++; $display("FAIL jal_link got %h want 24", dut.regfile.memory[1]); end
    checks++;
    if (dut.regfile.memory[9] !== 32'h30) begin errors++; $display("FAIL jalr_link got %h want 30", dut.regfile.memory[9]); end
    checks++;
    if (dut.regfile.memory[10] !== 32'd4) begin errors++; $display("FAIL jalr_target_x10 got %h want 4", dut.regfile.memory[10]); end
  endtask

  task automatic test_edge_cases();
    bit ok;
    clear_imem();
    imem[0]  = addi(5'd0, 5'd0, 12'd7);
    imem[1]  = addi(5'd1, 5'd0, 12'hFFF);
    imem[2]  = addi(5'd2, 5'd0, 12'd1);
    imem[3]  = enc_r(7'd0, 5'd2, 5'd1, 3'b010, 5'd4);
    imem[4]  = enc_r(7'd0, 5'd2, 5'd1, 3'b011, 5'd5);
    imem[5]  = addi(5'd6, 5'd0, 12'hFF8);
    imem[6]  = enc_i(12'h401, 5'd6, 3'b101, 5'd7, 7'b0010011);
    imem[7]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd8);
    imem[8]  = addi(5'd9, 5'd0, 12'd33);
    imem[9]  = enc_r(7'd0, 5'd9, 5'd2, 3'b001, 5'd10);
    imem[10] = enc_r(7'd0, 5'd9, 5'd1, 3'b101, 5'd11);
    imem[11] = {20'h12345, 5'd12, 7'b0110111};
    imem[12] = {20'h00001, 5'd13, 7'b0010111};
    do_reset(2);
    run_until(32'h34, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL edge_timeout got 0 want 1"); end
    checks++;
    if (dut.regfile.memory[0] !== 32'd0) begin errors++; $display("FAIL edge_x0 got %h want 0", dut.regfile.memory[0]); end
    checks++;
    if (dut.regfile.memory[4] !== 32'd1) begin errors++; $display("FAIL edge_slt got %h want 1", dut.regfile.memory[4]); end
    checks++;
    if (dut.regfile.memory[5] !== 32'd0) begin errors++; $display("FAIL edge_sltu got %h want 0", dut.regfile.memory[5]); end
    checks++;
    if (dut.regfile.memory[7] !== 32'hFFFFFFFC) begin errors++; $display("FAIL edge_srai got %h want fffffffc", dut.regfile.memory[7]); end
    checks++;
    if (dut.regfile.memory[8] !== 32'd2) begin errors++; $display("FAIL edge_sub got %h want 2", dut.regfile.memory[8]); end
    checks++;
    if (dut.regfile.memory[10] !== 32'd2) begin errors++; $display("FAIL edge_sll_shamt got %h want 2", dut.regfile.memory[10]); end
    checks++;
    if (dut.regfile.memory[11] !== 32'h7FFFFFFF) begin errors++; $display("FAIL edge_srl got %h want 7fffffff", dut.regfile.memory[11]); end
    checks++;
    if (dut.regfile.memory[12] !== 32'h12345000) begin errors++; $display("FAIL edge_lui got %h want 12345000", dut.regfile.memory[12]); end
    checks++;
    if (dut.regfile.memory[13] !== 32'h00001030) begin errors++; $display("FAIL edge_auipc got %h want 1030", dut.regfile.memory[13]); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_imem();
    imem[0] = addi(5'd3, 5'd0, 12'd9);
    imem[1] = addi(5'd1, 5'd0, 12'h100);
    imem[2] = enc_i(12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011);
    ld_hold = 1'b1;
    do_reset(2);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (d_rdata_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_reach_wait_load got 0 want 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (d_rdata_ready !== 1'b1) begin errors++; $display("FAIL mid_stall_ready got %b want 1", d_rdata_ready); end
    checks++;
    if (dut.regfile.memory[3] !== 32'd9) begin errors++; $display("FAIL mid_x3_before got %h want 9", dut.regfile.memory[3]); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (d_rdata_ready !== 1'b0) begin errors++; $display("FAIL mid_rdata_ready got %b want 0", d_rdata_ready); end
    checks++;
    if (dut.regfile.memory[3] !== 32'd0) begin errors++; $display("FAIL mid_x3_cleared got %h want 0", dut.regfile.memory[3]); end
    rst = 1'b0;
    ld_hold = 1'b0;
    #1;
    checks++;
    if (i_raddr_valid !== 1'b1 || i_raddr !== 32'h0) begin
      errors++; $display("FAIL mid_refetch got valid %b addr %h want 1 0", i_raddr_valid, i_raddr);
    end
    checks++;
    if (d_rdata_ready !== 1'b0 || d_raddr_valid !== 1'b0) begin
      errors++; $display("FAIL mid_data_idle got %b%b want 00", d_rdata_ready, d_raddr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load(0, 12'h055);
    test_store_load(3, 12'h066);
    test_branch_jump();
    test_edge_cases();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
